// File: rtl/ras_ctrl.sv
// rtl/ras_ctrl.sv - return address stack controller with checkpoint/restore
module ras_ctrl #(
  parameter int RAS_ENTRIES      = 8,
  parameter int LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES),
  parameter int RAS_TARGET_WIDTH = 31
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  output logic [RAS_TARGET_WIDTH-1:0] pop_target_out,
  output logic                        pop_target_valid_out,
  output logic [LOG_RAS_ENTRIES-1:0]  ckpt_ptr_out,
  output logic [LOG_RAS_ENTRIES:0]    ckpt_count_out,
  input  logic                        restore_valid,
  input  logic [LOG_RAS_ENTRIES-1:0]  restore_ptr,
  input  logic [LOG_RAS_ENTRIES:0]    restore_count
);

  localparam logic [LOG_RAS_ENTRIES:0] COUNT_MAX = (LOG_RAS_ENTRIES+1)'(RAS_ENTRIES);
  localparam logic [LOG_RAS_ENTRIES:0] COUNT_ONE = (LOG_RAS_ENTRIES+1)'(1);

  logic [RAS_TARGET_WIDTH-1:0] entries [RAS_ENTRIES];
  logic [LOG_RAS_ENTRIES-1:0]  ptr;
  logic [LOG_RAS_ENTRIES:0]    count;

  logic [LOG_RAS_ENTRIES-1:0]  ptr_inc;
  logic [LOG_RAS_ENTRIES-1:0]  ptr_dec;
  logic                        count_nz;
  logic                        do_push;
  logic                        do_pop;

  always_comb begin
    ptr_inc  = ptr + 1'b1;
    ptr_dec  = ptr - 1'b1;
    count_nz = (count != '0);
    do_push  = push_valid & ~restore_valid;
    do_pop   = pop_valid & ~restore_valid;
  end

  // Read side is purely combinational from the registered state.
  assign pop_target_out       = entries[ptr];
  assign pop_target_valid_out = do_pop & count_nz;
  assign ckpt_ptr_out         = ptr;
  assign ckpt_count_out       = count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr   <= '1;
      count <= '0;
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        entries[i] <= '0;
      end
    end else if (restore_valid) begin
      ptr   <= restore_ptr;
      count <= (restore_count > COUNT_MAX) ? COUNT_MAX : restore_count;
    end else if (do_push && do_pop) begin
      // Replace top in place: the return consumes it, the call supplies a new one.
      entries[ptr] <= push_target;
      if (!count_nz) begin
        count <= COUNT_ONE;
      end
    end else if (do_push) begin
      ptr              <= ptr_inc;
      entries[ptr_inc] <= push_target;
      if (count != COUNT_MAX) begin
        count <= count + 1'b1;
      end
    end else if (do_pop && count_nz) begin
      ptr   <= ptr_dec;
      count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_ras_ctrl.sv
// tb/tb_ras_ctrl.sv - randomized self-checking bench for ras_ctrl
module tb_ras_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        push_valid;
  logic [30:0] push_target;
  logic        pop_valid;
  logic [30:0] pop_target_out;
  logic        pop_target_valid_out;
  logic [2:0]  ckpt_ptr_out;
  logic [3:0]  ckpt_count_out;
  logic        restore_valid;
  logic [2:0]  restore_ptr;
  logic [3:0]  restore_count;

  int errors = 0;
  int checks = 0;

  // Reference stack: plain array with integer top index and depth.
  logic [30:0] m_mem [8];
  int          m_top;
  int          m_cnt;

  logic [30:0] last_target;
  logic        last_valid;

  always #5 CLK = ~CLK;

  ras_ctrl dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .push_valid          (push_valid),
    .push_target         (push_target),
    .pop_valid           (pop_valid),
    .pop_target_out      (pop_target_out),
    .pop_target_valid_out(pop_target_valid_out),
    .ckpt_ptr_out        (ckpt_ptr_out),
    .ckpt_count_out      (ckpt_count_out),
    .restore_valid       (restore_valid),
    .restore_ptr         (restore_ptr),
    .restore_count       (restore_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_top = 7;
    m_cnt = 0;
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
  endtask

  task automatic step(input bit rst, input bit psh, input logic [30:0] tgt, input bit pp,
                      input bit rs, input int rp, input int rc);
    @(negedge CLK);
    RST           = rst;
    push_valid    = psh;
    push_target   = tgt;
    pop_valid     = pp;
    restore_valid = rs;
    restore_ptr   = 3'(rp);
    restore_count = 4'(rc);
    #1;
    check_eq("pop_target", {1'b0, pop_target_out}, {1'b0, m_mem[m_top]});
    check_eq("pop_valid", {31'b0, pop_target_valid_out}, {31'b0, (pp && m_cnt != 0 && !rs)});
    check_eq("ckpt_ptr", {29'b0, ckpt_ptr_out}, m_top);
    check_eq("ckpt_count", {28'b0, ckpt_count_out}, m_cnt);
    last_target = pop_target_out;
    last_valid  = pop_target_valid_out;
    @(posedge CLK);
    if (rst) begin
      model_reset();
    end else if (rs) begin
      m_top = rp % 8;
      m_cnt = (rc > 8) ? 8 : rc;
    end else if (psh && pp) begin
      m_mem[m_top] = tgt;
      if (m_cnt == 0) m_cnt = 1;
    end else if (psh) begin
      m_top = (m_top + 1) % 8;
      m_mem[m_top] = tgt;
      if (m_cnt < 8) m_cnt++;
    end else if (pp && m_cnt > 0) begin
      m_top = (m_top + 7) % 8;
      m_cnt--;
    end
  endtask

  task automatic do_push(input logic [30:0] t); step(0, 1, t, 0, 0, 0, 0); endtask
  task automatic do_pop();  step(0, 0, '0, 1, 0, 0, 0); endtask
  task automatic do_idle(); step(0, 0, '0, 0, 0, 0, 0); endtask
  task automatic do_rst();  step(1, 0, '0, 0, 0, 0, 0); endtask

  initial begin
    RST = 1'b1; push_valid = 0; push_target = '0; pop_valid = 0;
    restore_valid = 0; restore_ptr = '0; restore_count = '0;
    repeat (2) @(posedge CLK);
    model_reset();

    // Reset state and push/pop ordering
    do_idle();
    check_eq("rst_ptr", {29'b0, ckpt_ptr_out}, 32'd7);
    check_eq("rst_target", {1'b0, pop_target_out}, 32'd0);
    do_push(31'h100); do_push(31'h200); do_push(31'h300);
    do_pop(); check_eq("pop1", {1'b0, last_target}, 32'h300); check_eq("pop1_v", {31'b0, last_valid}, 32'd1);
    do_pop(); check_eq("pop2", {1'b0, last_target}, 32'h200);
    do_pop(); check_eq("pop3", {1'b0, last_target}, 32'h100);
    do_pop(); check_eq("pop_empty_v", {31'b0, last_valid}, 32'd0);
    do_idle(); check_eq("empty_ptr", {29'b0, ckpt_ptr_out}, 32'd7);

    // Overflow wraps and overwrites oldest
    for (int i = 1; i <= 10; i++) do_push(31'(i));
    do_idle();
    check_eq("ovf_count", {28'b0, ckpt_count_out}, 32'd8);
    check_eq("ovf_ptr", {29'b0, ckpt_ptr_out}, 32'd1);
    do_pop(); check_eq("ovf_pop_first", {1'b0, last_target}, 32'hA);
    for (int i = 0; i < 7; i++) do_pop();
    check_eq("ovf_pop_last", {1'b0, last_target}, 32'h3);
    do_pop(); check_eq("ovf_pop9_v", {31'b0, last_valid}, 32'd0);

    // Combined push+pop, non-empty and empty
    do_rst();
    do_push(31'h100); do_push(31'h200);
    step(0, 1, 31'h555, 1, 0, 0, 0);
    check_eq("pp_target", {1'b0, last_target}, 32'h200);
    check_eq("pp_valid", {31'b0, last_valid}, 32'd1);
    do_idle();
    check_eq("pp_top", {1'b0, pop_target_out}, 32'h555);
    check_eq("pp_count", {28'b0, ckpt_count_out}, 32'd2);
    do_rst();
    step(0, 1, 31'h42, 1, 0, 0, 0);
    check_eq("pp0_valid", {31'b0, last_valid}, 32'd0);
    do_idle();
    check_eq("pp0_count", {28'b0, ckpt_count_out}, 32'd1);

    // Checkpoint restore overrides push/pop
    do_rst();
    do_push(31'h11); do_push(31'h22); do_push(31'h33);
    do_push(31'h777);
    step(0, 1, 31'h999, 1, 1, 2, 3);
    check_eq("rs_valid", {31'b0, last_valid}, 32'd0);
    do_idle();
    check_eq("rs_ptr", {29'b0, ckpt_ptr_out}, 32'd2);
    check_eq("rs_count", {28'b0, ckpt_count_out}, 32'd3);
    check_eq("rs_top", {1'b0, pop_target_out}, 32'h33);
    step(0, 0, '0, 0, 1, 5, 15);
    do_idle();
    check_eq("rs_sat", {28'b0, ckpt_count_out}, 32'd8);

    // Reset wins over a concurrent push
    do_rst();
    for (int i = 0; i < 5; i++) do_push(31'h40 + 31'(i));
    step(1, 1, 31'h1234, 0, 0, 0, 0);
    do_idle();
    check_eq("rstp_ptr", {29'b0, ckpt_ptr_out}, 32'd7);
    check_eq("rstp_count", {28'b0, ckpt_count_out}, 32'd0);
    check_eq("rstp_target", {1'b0, pop_target_out}, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      step(r == 0, $urandom_range(0, 1) == 1, 31'($urandom), $urandom_range(0, 1) == 1,
           r >= 1 && r < 7, $urandom_range(0, 7), $urandom_range(0, 15));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
